// File: rtl/galivan_fb_pkg.sv
// Shared types and widths for the double-buffered frame store controller.
package galivan_fb_pkg;

   localparam int unsigned FB_AW   = 17;
   localparam int unsigned PAGE_AW = 16;
   localparam int unsigned PIX_W   = 8;
   localparam int unsigned COORD_W = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PEND  = 2'd1,
      SWAP  = 2'd2,
      CLEAR = 2'd3
   } fb_state_e;

   // One VRAM write-port transaction.
   typedef struct packed {
      logic             we;
      logic [FB_AW-1:0] addr;
      logic [PIX_W-1:0] data;
   } fb_wr_s;

   // One VRAM read-port transaction.
   typedef struct packed {
      logic             re;
      logic [FB_AW-1:0] addr;
   } fb_rd_s;

endpackage

// File: rtl/fb_edge_rise.sv
// Registered rising-edge detector; previous value resets to 0.
module fb_edge_rise (
   input  logic clk_sys,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev_q, prev_d;
   logic rise_q, rise_d;

   // Next-state: remember level, flag 0->1 transition.
   always_comb begin
      prev_d = din;
      rise_d = din & ~prev_q;
   end

   // State registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/fb_page_ctrl.sv
// Double-buffer page controller: page swap sequencing, back-page clear
// engine and write-port arbitration for a 2x256x256x8 VRAM.
module fb_page_ctrl
   import galivan_fb_pkg::*;
#(
   parameter bit         CLEAR_EN       = 1'b1,
   parameter logic [7:0] CLEAR_COLOR    = 8'h00,
   parameter bit         SWAP_ON_VBLANK = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        wr_req,
   input  logic [7:0]  wr_x,
   input  logic [7:0]  wr_y,
   input  logic [7:0]  wr_data,
   input  logic        frame_done,
   input  logic        vblank,
   input  logic        rd_en,
   input  logic [7:0]  rd_x,
   input  logic [7:0]  rd_y,
   output logic        ram_we,
   output logic [16:0] ram_waddr,
   output logic [7:0]  ram_wdata,
   output logic        ram_re,
   output logic [16:0] ram_raddr,
   output logic        wr_page,
   output logic        swap_pulse,
   output logic        clear_busy,
   output logic        clear_overrun
);

   fb_state_e            state_q, state_d;
   logic                 wr_page_q, wr_page_d;
   logic                 swap_pulse_q, swap_pulse_d;
   logic                 clear_busy_q, clear_busy_d;
   logic                 overrun_q, overrun_d;
   logic                 pending_q, pending_d;
   logic [PAGE_AW-1:0]   clear_ptr_q, clear_ptr_d;
   fb_wr_s               wr_q, wr_d;
   fb_rd_s               rd_q, rd_d;

   logic                 fd_rise;
   logic                 vb_rise;
   logic [PAGE_AW-1:0]   pix_addr;

   fb_edge_rise u_fd_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .din     (frame_done),
      .rise    (fd_rise)
   );

   fb_edge_rise u_vb_edge (
      .clk_sys (clk_sys),
      .reset   (reset),
      .din     (vblank),
      .rise    (vb_rise)
   );

   assign pix_addr = {wr_y, wr_x};

   // Read path: front page is always the complement of the back page.
   always_comb begin
      rd_d    = rd_q;
      rd_d.re = rd_en;
      if (rd_en) begin
         rd_d.addr = {~wr_page_q, rd_y, rd_x};
      end
   end

   // Swap FSM, clear engine and write-port arbitration (core has priority).
   always_comb begin
      state_d      = state_q;
      wr_page_d    = wr_page_q;
      swap_pulse_d = 1'b0;
      clear_busy_d = 1'b0;
      overrun_d    = overrun_q;
      pending_d    = pending_q;
      clear_ptr_d  = clear_ptr_q;
      wr_d         = wr_q;
      wr_d.we      = 1'b0;

      if (wr_req) begin
         wr_d.we   = 1'b1;
         wr_d.addr = {wr_page_q, pix_addr};
         wr_d.data = wr_data;
      end

      unique case (state_q)
         RUN: begin
            if (fd_rise) begin
               state_d = SWAP_ON_VBLANK ? PEND : SWAP;
            end
         end
         PEND: begin
            if (vb_rise) begin
               state_d = SWAP;
            end
         end
         SWAP: begin
            state_d = CLEAR_EN ? CLEAR : RUN;
         end
         CLEAR: begin
            if (fd_rise) begin
               pending_d = 1'b1;
            end
            if (wr_req) begin
               // Core write lands on not-yet-cleared area: it will be wiped.
               if (pix_addr >= clear_ptr_q) begin
                  overrun_d = 1'b1;
               end
            end else begin
               wr_d.we     = 1'b1;
               wr_d.addr   = {wr_page_q, clear_ptr_q};
               wr_d.data   = CLEAR_COLOR;
               clear_ptr_d = clear_ptr_q + PAGE_AW'(1);
               if (clear_ptr_q == {PAGE_AW{1'b1}}) begin
                  if (pending_q || fd_rise) begin
                     pending_d = 1'b0;
                     state_d   = SWAP_ON_VBLANK ? PEND : SWAP;
                  end else begin
                     state_d   = RUN;
                  end
               end
            end
         end
         default: state_d = RUN;
      endcase

      // Page flips on entry to SWAP so the pulse and new page line up.
      if (state_d == SWAP) begin
         wr_page_d    = ~wr_page_q;
         swap_pulse_d = 1'b1;
      end
      clear_busy_d = (state_d == CLEAR);
   end

   // State registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= RUN;
         wr_page_q    <= 1'b0;
         swap_pulse_q <= 1'b0;
         clear_busy_q <= 1'b0;
         overrun_q    <= 1'b0;
         pending_q    <= 1'b0;
         clear_ptr_q  <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
      end else begin
         state_q      <= state_d;
         wr_page_q    <= wr_page_d;
         swap_pulse_q <= swap_pulse_d;
         clear_busy_q <= clear_busy_d;
         overrun_q    <= overrun_d;
         pending_q    <= pending_d;
         clear_ptr_q  <= clear_ptr_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
      end
   end

   assign ram_we        = wr_q.we;
   assign ram_waddr     = wr_q.addr;
   assign ram_wdata     = wr_q.data;
   assign ram_re        = rd_q.re;
   assign ram_raddr     = rd_q.addr;
   assign wr_page       = wr_page_q;
   assign swap_pulse    = swap_pulse_q;
   assign clear_busy    = clear_busy_q;
   assign clear_overrun = overrun_q;

endmodule

// File: tb/tb_fb_page_ctrl.sv
// Bench for fb_page_ctrl: one instance without clear, one with clear.
module tb_fb_page_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        wr_req = 1'b0;
   logic [7:0]  wr_x = '0, wr_y = '0, wr_data = '0;
   logic        frame_done = 1'b0, vblank = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_x = '0, rd_y = '0;

   logic        o0_ram_we, o0_ram_re, o0_wr_page, o0_swap_pulse, o0_clear_busy, o0_clear_overrun;
   logic [16:0] o0_ram_waddr, o0_ram_raddr;
   logic [7:0]  o0_ram_wdata;
   logic        o1_ram_we, o1_ram_re, o1_wr_page, o1_swap_pulse, o1_clear_busy, o1_clear_overrun;
   logic [16:0] o1_ram_waddr, o1_ram_raddr;
   logic [7:0]  o1_ram_wdata;

   int          checks = 0;
   int          errors = 0;
   logic [24:0] exp_q[$];
   logic [24:0] sb_e;
   bit          mon1_en = 1'b0;

   always #5 clk_sys = ~clk_sys;

   fb_page_ctrl #(.CLEAR_EN(1'b0), .CLEAR_COLOR(8'h00), .SWAP_ON_VBLANK(1'b1)) u_dut0 (
      .clk_sys(clk_sys), .reset(reset), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .frame_done(frame_done), .vblank(vblank), .rd_en(rd_en),
      .rd_x(rd_x), .rd_y(rd_y), .ram_we(o0_ram_we), .ram_waddr(o0_ram_waddr),
      .ram_wdata(o0_ram_wdata), .ram_re(o0_ram_re), .ram_raddr(o0_ram_raddr),
      .wr_page(o0_wr_page), .swap_pulse(o0_swap_pulse), .clear_busy(o0_clear_busy),
      .clear_overrun(o0_clear_overrun));

   fb_page_ctrl #(.CLEAR_EN(1'b1), .CLEAR_COLOR(8'h00), .SWAP_ON_VBLANK(1'b1)) u_dut1 (
      .clk_sys(clk_sys), .reset(reset), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .frame_done(frame_done), .vblank(vblank), .rd_en(rd_en),
      .rd_x(rd_x), .rd_y(rd_y), .ram_we(o1_ram_we), .ram_waddr(o1_ram_waddr),
      .ram_wdata(o1_ram_wdata), .ram_re(o1_ram_re), .ram_raddr(o1_ram_raddr),
      .wr_page(o1_wr_page), .swap_pulse(o1_swap_pulse), .clear_busy(o1_clear_busy),
      .clear_overrun(o1_clear_overrun));

   // Write-port scoreboard for the clearing instance.
   always @(negedge clk_sys) begin
      if (mon1_en && o1_ram_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_sb unexpected write addr=%h data=%h", o1_ram_waddr, o1_ram_wdata);
         end else begin
            sb_e = exp_q.pop_front();
            if ({o1_ram_waddr, o1_ram_wdata} !== sb_e) begin
               errors++;
               $display("FAIL wr_sb got addr=%h data=%h expected addr=%h data=%h",
                        o1_ram_waddr, o1_ram_wdata, sb_e[24:8], sb_e[7:0]);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk_sys);
      reset = 1'b1; wr_req = 1'b0; frame_done = 1'b0; vblank = 1'b0; rd_en = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if ({o0_ram_we, o0_ram_waddr, o0_ram_wdata, o0_ram_re, o0_ram_raddr, o0_wr_page,
           o0_swap_pulse, o0_clear_busy, o0_clear_overrun} !== 48'h0) begin
         errors++; $display("FAIL reset_dut0 outputs not all zero");
      end
      checks++;
      if ({o1_ram_we, o1_ram_waddr, o1_ram_wdata, o1_ram_re, o1_ram_raddr, o1_wr_page,
           o1_swap_pulse, o1_clear_busy, o1_clear_overrun} !== 48'h0) begin
         errors++; $display("FAIL reset_dut1 outputs not all zero");
      end
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_read();
      rd_en = 1'b1; rd_x = 8'd5; rd_y = 8'd3;
      @(negedge clk_sys);
      rd_en = 1'b0;
      checks++;
      if (o0_ram_re !== 1'b1 || o0_ram_raddr !== 17'h10305) begin
         errors++; $display("FAIL read0 re=%b raddr=%h expected re=1 raddr=10305", o0_ram_re, o0_ram_raddr);
      end
      checks++;
      if (o1_ram_re !== 1'b1 || o1_ram_raddr !== 17'h10305) begin
         errors++; $display("FAIL read1 re=%b raddr=%h expected re=1 raddr=10305", o1_ram_re, o1_ram_raddr);
      end
      @(negedge clk_sys);
      checks++;
      if (o0_ram_re !== 1'b0) begin
         errors++; $display("FAIL read_idle re=%b expected 0", o0_ram_re);
      end
   endtask

   task automatic test_write();
      wr_req = 1'b1; wr_x = 8'd2; wr_y = 8'd1; wr_data = 8'hE0;
      @(negedge clk_sys);
      wr_req = 1'b0;
      checks++;
      if (o0_ram_we !== 1'b1 || o0_ram_waddr !== 17'h00102 || o0_ram_wdata !== 8'hE0) begin
         errors++; $display("FAIL write0 we=%b addr=%h data=%h expected 1 00102 e0", o0_ram_we, o0_ram_waddr, o0_ram_wdata);
      end
      checks++;
      if (o1_ram_we !== 1'b1 || o1_ram_waddr !== 17'h00102 || o1_ram_wdata !== 8'hE0) begin
         errors++; $display("FAIL write1 we=%b addr=%h data=%h expected 1 00102 e0", o1_ram_we, o1_ram_waddr, o1_ram_wdata);
      end
      @(negedge clk_sys);
      checks++;
      if (o0_ram_we !== 1'b0) begin
         errors++; $display("FAIL write_idle we=%b expected 0", o0_ram_we);
      end
   endtask

   task automatic test_swap_vblank();
      int sw = 0;
      int we0 = 0;
      frame_done = 1'b1;
      repeat (100) begin
         @(negedge clk_sys);
         sw += int'(o0_swap_pulse) + int'(o1_swap_pulse);
      end
      checks++;
      if (sw != 0 || o0_wr_page !== 1'b0 || o1_wr_page !== 1'b0) begin
         errors++; $display("FAIL pend_hold swaps=%0d page0=%b page1=%b expected 0 0 0", sw, o0_wr_page, o1_wr_page);
      end
      vblank = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (o0_swap_pulse !== 1'b0 || o1_swap_pulse !== 1'b0) begin
         errors++; $display("FAIL swap_early pulse0=%b pulse1=%b expected 0 0", o0_swap_pulse, o1_swap_pulse);
      end
      @(negedge clk_sys);
      checks++;
      if (o0_swap_pulse !== 1'b1 || o1_swap_pulse !== 1'b1 || o0_wr_page !== 1'b1 || o1_wr_page !== 1'b1) begin
         errors++; $display("FAIL swap_pulse pulse=%b%b page=%b%b expected 11 11", o0_swap_pulse, o1_swap_pulse, o0_wr_page, o1_wr_page);
      end
      @(negedge clk_sys);
      checks++;
      if (o0_swap_pulse !== 1'b0 || o0_clear_busy !== 1'b0 || o1_clear_busy !== 1'b1) begin
         errors++; $display("FAIL post_swap pulse0=%b busy0=%b busy1=%b expected 0 0 1", o0_swap_pulse, o0_clear_busy, o1_clear_busy);
      end
      rd_en = 1'b1; rd_x = 8'd5; rd_y = 8'd3;
      repeat (20) begin
         @(negedge clk_sys);
         we0 += int'(o0_ram_we);
      end
      rd_en = 1'b0;
      checks++;
      if (we0 != 0) begin
         errors++; $display("FAIL no_clear_writes count=%0d expected 0", we0);
      end
      checks++;
      if (o0_ram_raddr !== 17'h00305) begin
         errors++; $display("FAIL front_page raddr=%h expected 00305", o0_ram_raddr);
      end
      checks++;
      if (o1_ram_we !== 1'b1 || o1_ram_waddr[16] !== 1'b1 || o1_ram_wdata !== 8'h00) begin
         errors++; $display("FAIL clear_active we=%b addr=%h data=%h expected 1 1xxxx 00", o1_ram_we, o1_ram_waddr, o1_ram_wdata);
      end
      // Reset in the middle of the clear.
      reset = 1'b1; frame_done = 1'b0; vblank = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (o1_wr_page !== 1'b0 || o1_clear_busy !== 1'b0 || o1_ram_we !== 1'b0) begin
         errors++; $display("FAIL reset_mid_clear page=%b busy=%b we=%b expected 0 0 0", o1_wr_page, o1_clear_busy, o1_ram_we);
      end
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_simultaneous_edges();
      int sw = 0;
      frame_done = 1'b1; vblank = 1'b1;
      repeat (10) begin
         @(negedge clk_sys);
         sw += int'(o0_swap_pulse) + int'(o1_swap_pulse);
      end
      checks++;
      if (sw != 0) begin
         errors++; $display("FAIL simul_no_swap swaps=%0d expected 0", sw);
      end
      vblank = 1'b0;
      repeat (3) @(negedge clk_sys);
      vblank = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if (o0_swap_pulse !== 1'b1 || o0_wr_page !== 1'b1 || o1_swap_pulse !== 1'b1) begin
         errors++; $display("FAIL simul_swap pulse0=%b page0=%b pulse1=%b expected 1 1 1", o0_swap_pulse, o0_wr_page, o1_swap_pulse);
      end
      apply_reset();
   endtask

   task automatic test_clear();
      int ptr = 0;
      int step = 0;
      int chk_ov = 0;
      int sw = 0;
      logic [15:0] a;
      mon1_en = 1'b1;
      frame_done = 1'b1;
      repeat (5) @(negedge clk_sys);
      vblank = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if (o1_swap_pulse !== 1'b1 || o1_wr_page !== 1'b1) begin
         errors++; $display("FAIL clr_swap pulse=%b page=%b expected 1 1", o1_swap_pulse, o1_wr_page);
      end
      @(negedge clk_sys);
      checks++;
      if (o1_clear_busy !== 1'b1) begin
         errors++; $display("FAIL clr_busy_start busy=%b expected 1", o1_clear_busy);
      end
      while (ptr < 65536) begin
         if (ptr == 32'h1000) begin frame_done = 1'b0; vblank = 1'b0; end
         if (ptr == 32'h2000) frame_done = 1'b1;
         if (ptr == 32'h3000) vblank = 1'b1;
         if (ptr == 32'hFFFF) begin
            checks++;
            if (o1_clear_busy !== 1'b1) begin
               errors++; $display("FAIL clr_busy_last busy=%b expected 1", o1_clear_busy);
            end
         end
         wr_req = 1'b0;
         if (ptr == 32'h0100 && step < 2) begin
            a = (step == 0) ? 16'h0050 : 16'h8000;
            wr_req = 1'b1; wr_y = a[15:8]; wr_x = a[7:0];
            wr_data = (step == 0) ? 8'h5A : 8'hA5;
            exp_q.push_back({1'b1, a, wr_data});
            step++;
            chk_ov = step;
         end else begin
            exp_q.push_back({1'b1, 16'(ptr), 8'h00});
            ptr++;
         end
         @(negedge clk_sys);
         sw += int'(o1_swap_pulse);
         if (chk_ov == 1) begin
            checks++;
            if (o1_clear_overrun !== 1'b0) begin
               errors++; $display("FAIL overrun_below got=%b expected 0", o1_clear_overrun);
            end
         end else if (chk_ov == 2) begin
            checks++;
            if (o1_clear_overrun !== 1'b1) begin
               errors++; $display("FAIL overrun_above got=%b expected 1", o1_clear_overrun);
            end
         end
         chk_ov = 0;
      end
      wr_req = 1'b0;
      checks++;
      if (o1_clear_busy !== 1'b0 || sw != 0 || o1_wr_page !== 1'b1) begin
         errors++; $display("FAIL clr_end busy=%b swaps=%0d page=%b expected 0 0 1", o1_clear_busy, sw, o1_wr_page);
      end
      // Pending frame waits for a fresh vblank edge.
      vblank = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++;
      if (exp_q.size() != 0 || o1_swap_pulse !== 1'b0 || o1_clear_overrun !== 1'b1) begin
         errors++; $display("FAIL clr_drain left=%0d pulse=%b overrun=%b expected 0 0 1", exp_q.size(), o1_swap_pulse, o1_clear_overrun);
      end
      vblank = 1'b1;
      repeat (2) @(negedge clk_sys);
      checks++;
      if (o1_swap_pulse !== 1'b1 || o1_wr_page !== 1'b0) begin
         errors++; $display("FAIL pending_swap pulse=%b page=%b expected 1 0", o1_swap_pulse, o1_wr_page);
      end
      @(negedge clk_sys);
      checks++;
      if (o1_clear_busy !== 1'b1) begin
         errors++; $display("FAIL clr2_busy busy=%b expected 1", o1_clear_busy);
      end
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({1'b0, 16'(i), 8'h00});
         @(negedge clk_sys);
      end
      reset = 1'b1; frame_done = 1'b0; vblank = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (o1_wr_page !== 1'b0 || o1_clear_busy !== 1'b0 || o1_ram_we !== 1'b0 || o1_clear_overrun !== 1'b0) begin
         errors++; $display("FAIL clr2_reset page=%b busy=%b we=%b overrun=%b expected 0 0 0 0",
                            o1_wr_page, o1_clear_busy, o1_ram_we, o1_clear_overrun);
      end
      reset = 1'b0;
      @(negedge clk_sys);
      mon1_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL clr2_drain left=%0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_swap_vblank();
      test_simultaneous_edges();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
